feature_row_cache_kxk: RTL and testbench
========================================

FEATURE_ROW_CACHE_KXK -- requirements
Module: feature_row_cache_kxk

Interface
REQ-001 Parameter FEATURE_WIDTH, default `FEATURE_WIDTH, bit width of one feature element.
REQ-002 Parameter PE_CORE_NUM, default `PE_CORE_NUM, number of parallel channels per beat.
REQ-003 Parameter KERNEL_ROWS, default 3, window height K; legal range 2..7.
REQ-004 Parameter MAX_COL, default 1024, line-buffer depth per row per channel.
REQ-005 Parameter REBUILD_GROUP, default 8, channel offset used in rebuild mode.
REQ-006 system_clk  in  1  sole clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 feature_output_data  in  PE_CORE_NUM*FEATURE_WIDTH  one column beat, channel i at bits [(i+1)*FW-1 : i*FW].
REQ-009 feature_output_valid  in  1  beat qualifier.
REQ-010 start  in  1  single-cycle pulse; latches configuration and begins a frame.
REQ-011 col_size  in  10  columns per row; sampled only on accepted start.
REQ-012 row_size  in  10  rows per frame; sampled only on accepted start.
REQ-013 pad_en  in  1  1 = emit windows from row 0 with zero top padding; sampled on start.
REQ-014 rebuild_structure  in  1  channel cascade mode; sampled on start.
REQ-015 feature_cache_data  out  PE_CORE_NUM*K*FEATURE_WIDTH  per channel K elements, oldest row in MSBs, current row in LSBs.
REQ-016 feature_cache_valid  out  1  window qualifier.
REQ-017 busy  out  1  high in FILL or STREAM.
REQ-018 frame_done  out  1  one-cycle pulse after last beat of frame.
REQ-019 cfg_error  out  1  one-cycle pulse when start is rejected.

Function
REQ-020 FSM states IDLE, FILL, STREAM, DONE; reset enters IDLE.
REQ-021 IDLE: start with 1<=col_size<=MAX_COL and K<=row_size (or pad_en=1 and row_size>=1) -> latch config, clear col/row counters, go FILL if pad_en=0 else STREAM; otherwise pulse cfg_error next cycle, stay IDLE.
REQ-022 start outside IDLE is ignored, no cfg_error.
REQ-023 feature_output_valid in IDLE or DONE is ignored; no buffer write, no output.
REQ-024 Each accepted beat writes the line buffers at address col_cnt; col_cnt wraps col_size-1 -> 0 and increments row_cnt.
REQ-025 FILL: beats write buffers only, feature_cache_valid stays 0; at end of row K-2 go STREAM.
REQ-026 STREAM: every accepted beat produces exactly one window, registered, feature_cache_valid high exactly 1 cycle after the beat (latency 1).
REQ-027 Window slot j (j=0 current .. K-1 oldest) = input row row_cnt-j at column col_cnt; with pad_en=1, slots with row_cnt-j<0 SHALL be zero regardless of buffer contents.
REQ-028 Line buffer is K-1 rows deep per channel; write of current beat and read of same column occur in the same beat (read-before-write semantics).
REQ-029 rebuild_structure=1: channel i>=REBUILD_GROUP writes, as its newest-row input, the oldest-row output of channel i-REBUILD_GROUP instead of its own input element; channels below REBUILD_GROUP unaffected; output slot 0 remains own input element.
REQ-030 After the last beat (row row_size-1, col col_size-1) go DONE; DONE lasts 1 cycle with frame_done=1, then IDLE.
REQ-031 Beat accepted in the same cycle as start is ignored.
REQ-032 feature_cache_data holds last window when feature_cache_valid=0.

Reset
REQ-033 rst_n low: FSM IDLE, counters 0, feature_cache_data 0, feature_cache_valid/busy/frame_done/cfg_error 0, effective immediately (asynchronous).
REQ-034 Line-buffer RAM contents not reset; pad masking (REQ-027) guarantees no stale data in padded slots after mid-frame reset.
REQ-035 Reset mid-frame aborts the frame with no frame_done; next start begins cleanly.

Verification
REQ-036 K=3, col_size=4, row_size=4, pad_en=0, ramp data value=row*4+col: first valid 1 cycle after beat (row2,col0), channel 0 window {0,4,8}; 8 windows total; frame_done 1 cycle after last window cycle.
REQ-037 Same with pad_en=1: 16 windows; row0 col1 window {0,0,1}; row1 col3 window {0,3,7}.
REQ-038 start with col_size=0 or col_size=MAX_COL+1 -> cfg_error pulse, busy stays 0, subsequent beats produce no valid.
REQ-039 rebuild_structure=1, PE_CORE_NUM=16: channel 8 newest-row buffer entry equals channel 0 oldest-row value of same column one row earlier.
REQ-040 rst_n asserted mid-row 2 with pad_en=1, then new frame of all-ones data: row0 windows {0,0,1} in every channel, no stale values.
REQ-041 Gapped valid (1 beat every 3 cycles) gives identical window sequence to back-to-back stimulus.

Source files
------------

// File: rtl/feature_row_cache_kxk.sv
// Row line-buffer cache: turns a stream of column beats into K-row column windows per channel,
// with optional zero top padding and a cross-channel cascade ("rebuild") mode.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif
`ifndef PE_CORE_NUM
`define PE_CORE_NUM 16
`endif

module feature_row_cache_kxk #(
    parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
    parameter int PE_CORE_NUM   = `PE_CORE_NUM,
    parameter int KERNEL_ROWS   = 3,
    parameter int MAX_COL       = 1024,
    parameter int REBUILD_GROUP = 8
) (
    input  logic                                           system_clk,
    input  logic                                           rst_n,
    input  logic [PE_CORE_NUM*FEATURE_WIDTH-1:0]           feature_output_data,
    input  logic                                           feature_output_valid,
    input  logic                                           start,
    input  logic [9:0]                                     col_size,
    input  logic [9:0]                                     row_size,
    input  logic                                           pad_en,
    input  logic                                           rebuild_structure,
    output logic [PE_CORE_NUM*KERNEL_ROWS*FEATURE_WIDTH-1:0] feature_cache_data,
    output logic                                           feature_cache_valid,
    output logic                                           busy,
    output logic                                           frame_done,
    output logic                                           cfg_error
);
    localparam int FW = FEATURE_WIDTH;
    localparam int K  = KERNEL_ROWS;
    localparam int BW = PE_CORE_NUM * FW;
    localparam int WW = PE_CORE_NUM * K * FW;
    localparam int AW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [9:0]      r_col_cnt;
    logic [9:0]      r_row_cnt;
    logic [9:0]      r_col_size;
    logic [9:0]      r_row_size;
    logic            r_rebuild;
    logic            w_start_ok;
    logic            w_beat;
    logic            w_col_last;
    logic            w_row_last;
    logic [AW-1:0]   w_addr;
    logic [BW-1:0]   w_new;
    logic [WW-1:0]   w_win;
    logic [WW-1:0]   r_win;
    logic            r_win_valid;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_cfg_error;

    // r_lb[0] holds the previous row, r_lb[K-2] the oldest buffered row
    logic [BW-1:0]   r_lb [K-1][MAX_COL];
    logic [BW-1:0]   w_rd [K-1];

    assign w_start_ok = start && (col_size != 10'd0) && (int'(col_size) <= MAX_COL) &&
                        ((int'(row_size) >= K) || (pad_en && (row_size != 10'd0)));
    assign w_beat     = feature_output_valid && ((r_state == S_FILL) || (r_state == S_STREAM));
    assign w_col_last = (r_col_cnt == (r_col_size - 10'd1));
    assign w_row_last = (r_row_cnt == (r_row_size - 10'd1));
    assign w_addr     = r_col_cnt[AW-1:0];

    for (genvar r = 0; r < K - 1; r++) begin : g_rd
        assign w_rd[r] = r_lb[r][w_addr];
    end

    // Rows not yet written in this frame read as zero, so stale RAM never leaks out
    for (genvar c = 0; c < PE_CORE_NUM; c++) begin : g_ch
        assign w_win[(c*K)*FW +: FW] = feature_output_data[c*FW +: FW];
        for (genvar j = 1; j < K; j++) begin : g_slot
            assign w_win[(c*K+j)*FW +: FW] = (r_row_cnt >= 10'(j)) ? w_rd[j-1][c*FW +: FW] : '0;
        end
        if (c >= REBUILD_GROUP) begin : g_casc
            assign w_new[c*FW +: FW] = r_rebuild ? w_win[((c-REBUILD_GROUP)*K+K-1)*FW +: FW]
                                                 : feature_output_data[c*FW +: FW];
        end else begin : g_own
            assign w_new[c*FW +: FW] = feature_output_data[c*FW +: FW];
        end
    end

    // Line-buffer shift: read-before-write at the current column, each row moves one deeper
    always_ff @(posedge system_clk) begin
        if (w_beat) begin
            r_lb[0][w_addr] <= w_new;
            for (int r = 1; r < K - 1; r++) begin
                r_lb[r][w_addr] <= w_rd[r-1];
            end
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = pad_en ? S_STREAM : S_FILL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FILL: begin
                if (w_beat && w_col_last && (r_row_cnt == 10'(K - 2))) begin
                    w_state_nxt = S_STREAM;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_STREAM: begin
                if (w_beat && w_col_last && w_row_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Configuration latch and column/row counters
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt  <= 10'd0;
            r_row_cnt  <= 10'd0;
            r_col_size <= 10'd0;
            r_row_size <= 10'd0;
            r_rebuild  <= 1'b0;
        end else if ((r_state == S_IDLE) && w_start_ok) begin
            r_col_cnt  <= 10'd0;
            r_row_cnt  <= 10'd0;
            r_col_size <= col_size;
            r_row_size <= row_size;
            r_rebuild  <= rebuild_structure;
        end else if (w_beat) begin
            if (w_col_last) begin
                r_col_cnt <= 10'd0;
                r_row_cnt <= r_row_cnt + 10'd1;
            end else begin
                r_col_cnt <= r_col_cnt + 10'd1;
            end
        end
    end

    // Registered outputs; window data holds its last value between windows
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win        <= '0;
            r_win_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_error  <= 1'b0;
        end else begin
            r_win_valid  <= w_beat && (r_state == S_STREAM);
            if (w_beat && (r_state == S_STREAM)) begin
                r_win <= w_win;
            end
            r_busy       <= (w_state_nxt == S_FILL) || (w_state_nxt == S_STREAM);
            r_frame_done <= (r_state == S_DONE);
            r_cfg_error  <= start && (r_state == S_IDLE) && !w_start_ok;
        end
    end

    assign feature_cache_data  = r_win;
    assign feature_cache_valid = r_win_valid;
    assign busy                = r_busy;
    assign frame_done          = r_frame_done;
    assign cfg_error           = r_cfg_error;

endmodule

// File: tb/tb_feature_row_cache_kxk.sv
// Directed bench for feature_row_cache_kxk: K=3, 16 channels of 8 bits, MAX_COL=8.
module tb_feature_row_cache_kxk;
    localparam int FW = 8;
    localparam int PE = 16;
    localparam int K  = 3;
    localparam int WW = PE * K * FW;

    logic            system_clk = 1'b0;
    logic            rst_n;
    logic [PE*FW-1:0] feature_output_data;
    logic            feature_output_valid;
    logic            start;
    logic [9:0]      col_size;
    logic [9:0]      row_size;
    logic            pad_en;
    logic            rebuild_structure;
    logic [WW-1:0]   feature_cache_data;
    logic            feature_cache_valid;
    logic            busy;
    logic            frame_done;
    logic            cfg_error;

    int              checks = 0;
    int              failures = 0;
    int              dmode = 0;
    logic [WW-1:0]   last_exp = '0;
    logic [WW-1:0]   cap_q[$];
    logic [WW-1:0]   qa[$];
    logic [WW-1:0]   ones_row0;

    feature_row_cache_kxk #(
        .FEATURE_WIDTH(FW), .PE_CORE_NUM(PE), .KERNEL_ROWS(K), .MAX_COL(8), .REBUILD_GROUP(8)
    ) dut (
        .system_clk(system_clk), .rst_n(rst_n),
        .feature_output_data(feature_output_data), .feature_output_valid(feature_output_valid),
        .start(start), .col_size(col_size), .row_size(row_size), .pad_en(pad_en),
        .rebuild_structure(rebuild_structure), .feature_cache_data(feature_cache_data),
        .feature_cache_valid(feature_cache_valid), .busy(busy), .frame_done(frame_done),
        .cfg_error(cfg_error)
    );

    always #5 system_clk = ~system_clk;

    function automatic logic [7:0] val(input int ch, input int r, input int c);
        if (dmode == 1) return 8'd1;
        else return 8'(ch * 16 + r * 4 + c);
    endfunction

    // Expected window: slot j is row r-j (zero above the frame); cascaded channels see the
    // source channel's oldest row, i.e. data from K-1 rows before the row that wrote them.
    function automatic logic [WW-1:0] exp_win(input int r, input int c, input bit rb);
        logic [WW-1:0] w;
        logic [7:0]    e;
        w = '0;
        for (int ch = 0; ch < PE; ch++) begin
            for (int j = 0; j < K; j++) begin
                if (j == 0) e = val(ch, r, c);
                else if (r - j < 0) e = 8'd0;
                else if (rb && ch >= 8) e = (r - j - (K - 1) >= 0) ? val(ch - 8, r - j - (K - 1), c) : 8'd0;
                else e = val(ch, r - j, c);
                w[(ch*K+j)*FW +: FW] = e;
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int cs, input int rs, input bit pad, input bit rb, input bit with_beat);
        start = 1'b1;
        col_size = 10'(cs);
        row_size = 10'(rs);
        pad_en = pad;
        rebuild_structure = rb;
        feature_output_valid = with_beat;
        feature_output_data = {PE{8'hEE}};
        @(negedge system_clk);
        start = 1'b0;
        feature_output_valid = 1'b0;
    endtask

    task automatic beat(input int r, input int c, input bit pad, input bit rb, input int gap);
        bit ev;
        for (int g = 0; g < gap; g++) begin
            @(negedge system_clk);
            chk("gap_valid", feature_cache_valid, 0);
            chk("gap_hold", feature_cache_data, last_exp);
        end
        ev = pad || (r >= K - 1);
        feature_output_valid = 1'b1;
        for (int ch = 0; ch < PE; ch++) feature_output_data[ch*FW +: FW] = val(ch, r, c);
        @(negedge system_clk);
        feature_output_valid = 1'b0;
        chk("win_valid", feature_cache_valid, ev);
        if (ev) begin
            last_exp = exp_win(r, c, rb);
            chk("win_data", feature_cache_data, last_exp);
            cap_q.push_back(feature_cache_data);
        end
    endtask

    task automatic run_frame(input int cs, input int rs, input bit pad, input bit rb, input int gap);
        cap_q.delete();
        for (int r = 0; r < rs; r++)
            for (int c = 0; c < cs; c++)
                beat(r, c, pad, rb, gap);
        chk("done_not_yet", frame_done, 0);
        chk("busy_in_done", busy, 0);
        @(negedge system_clk);
        chk("frame_done", frame_done, 1);
        @(negedge system_clk);
        chk("frame_done_pulse", frame_done, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        feature_output_data = '0;
        feature_output_valid = 1'b0;
        start = 1'b0;
        col_size = 10'd0;
        row_size = 10'd0;
        pad_en = 1'b0;
        rebuild_structure = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge system_clk);
        chk("rst_data", feature_cache_data, 0);
        chk("rst_valid", feature_cache_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cfg_err", cfg_error, 0);
        rst_n = 1'b1;
        @(negedge system_clk);

        // Rejected configurations
        do_start(0, 4, 0, 0, 0);
        chk("cfg_err_col0", cfg_error, 1);
        chk("cfg_err_col0_busy", busy, 0);
        beat(0, 0, 0, 0, 0);
        chk("cfg_err_pulse", cfg_error, 0);
        beat(0, 1, 0, 0, 0);
        do_start(9, 4, 0, 0, 0);
        chk("cfg_err_col9", cfg_error, 1);
        chk("cfg_err_col9_busy", busy, 0);
        do_start(4, 2, 0, 0, 0);
        chk("cfg_err_rows", cfg_error, 1);
        @(negedge system_clk);

        // No padding, back-to-back, with a beat coincident with start
        dmode = 0;
        do_start(4, 4, 0, 0, 1);
        chk("busy_fill", busy, 1);
        chk("no_cfg_err", cfg_error, 0);
        run_frame(4, 4, 0, 0, 0);
        chk("nopad_count", cap_q.size(), 8);
        qa = cap_q;
        chk("nopad_first", qa[0][23:0], 24'h000408);

        // Same frame, one beat every three cycles
        do_start(4, 4, 0, 0, 0);
        run_frame(4, 4, 0, 0, 2);
        chk("gap_count", cap_q.size(), qa.size());
        for (int i = 0; i < qa.size() && i < cap_q.size(); i++) chk("gap_seq", cap_q[i], qa[i]);

        // Top padding; a start during streaming must be ignored
        do_start(4, 4, 1, 0, 0);
        start = 1'b1;
        col_size = 10'd0;
        @(negedge system_clk);
        start = 1'b0;
        chk("start_in_stream_err", cfg_error, 0);
        chk("start_in_stream_busy", busy, 1);
        run_frame(4, 4, 1, 0, 0);
        chk("pad_count", cap_q.size(), 16);
        chk("pad_r0c1", cap_q[1][23:0], 24'h000001);
        chk("pad_r1c3", cap_q[7][23:0], 24'h000307);

        // Channel cascade
        do_start(4, 4, 0, 1, 0);
        run_frame(4, 4, 0, 1, 0);
        chk("casc_count", cap_q.size(), 8);
        chk("casc_ch8_r3c2", cap_q[6][207:200], 8'd2);
        chk("casc_ch8_r3c3", cap_q[7][207:200], 8'd3);
        chk("casc_ch8_own", cap_q[6][199:192], 8'd142);

        // Reset in the middle of row 2, then a fresh all-ones frame
        do_start(4, 4, 1, 0, 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (r < 2 || c < 2) beat(r, c, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", feature_cache_valid, 0);
        chk("midrst_data", feature_cache_data, 0);
        chk("midrst_busy", busy, 0);
        last_exp = '0;
        @(negedge system_clk);
        rst_n = 1'b1;
        @(negedge system_clk);
        chk("midrst_no_done", frame_done, 0);
        dmode = 1;
        do_start(4, 2, 1, 0, 0);
        run_frame(4, 2, 1, 0, 0);
        ones_row0 = {PE{24'h000001}};
        chk("ones_count", cap_q.size(), 8);
        chk("ones_r0c0", cap_q[0], ones_row0);
        chk("ones_r0c3", cap_q[3], ones_row0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
